cotm32_clint: RTL
=================

Name: cotm32_clint

Overview:
Core-local interruptor for cotm32: the memory-mapped responder behind the CLINT MMR window (msip, mtimecmp, mtime).
- Sits on the data-memory bus next to RAM.
- Owns the 64-bit real-time counter and the compare and software-interrupt registers.
- Drives the msip/mtip lines sampled into the mip CSR by the trap/CSR unit.

Parameters:
TICK_DIV, 1, clk cycles per mtime increment (>=1); 1 means increment every cycle
MTIMECMP_RST, 64'hFFFF_FFFF_FFFF_FFFF, reset value of mtimecmp

Ports:
clk  input  1  core clock
rst  input  1  synchronous active-high reset
req_valid_i  input  1  bus request, address already within CLINT window
req_we_i  input  1  1 = write, 0 = read
req_addr_i  input  32  byte address (XLEN)
req_wdata_i  input  32  write data
req_wstrb_i  input  4  byte enables for writes
resp_valid_o  output  1  response strobe, one cycle after request
resp_rdata_o  output  32  read data, valid with resp_valid_o
resp_err_o  output  1  access fault (unmapped or misaligned address)
msip_o  output  1  machine software interrupt pending, to mip.msip
mtip_o  output  1  machine timer interrupt pending, to mip.mtip
mtime_o  output  64  current mtime value (for time/cycle CSRs)

Behaviour:
- Clocking and reset: one clock domain, clk. rst is synchronous, active-high, and overrides every other event in that cycle.
- Reset values:
  - mtime=0, mtimecmp=MTIMECMP_RST, msip=0, prescaler count=0.
  - resp_valid_o=0, resp_rdata_o=0, resp_err_o=0, msip_o=0, mtip_o=0.
- Register map (full 32-bit decode):
  - 0x0200_0000: msip. Bit 0 is R/W; bits 31:1 read 0, writes ignored.
  - 0x0200_4000 / 0x0200_4004: mtimecmp low / high word, R/W.
  - 0x0200_BFF8 / 0x0200_BFFC: mtime low / high word, R/W.
- Invalid accesses:
  - Any other address, or addr[1:0]!=0, gives resp_err_o=1 and resp_rdata_o=0.
  - Such a write has no side effect.
  - The trap unit maps the error to load/store access fault.
- Request handshake:
  - Always ready. Every cycle with req_valid_i=1 is accepted.
  - Back-to-back requests are allowed.
- Response timing:
  - resp_valid_o is asserted exactly 1 cycle after acceptance, for 1 cycle. It is otherwise 0.
  - resp_rdata_o and resp_err_o hold their value while resp_valid_o=0; they are don't-care for checking in those cycles.
- Read data: the pre-edge register value in the acceptance cycle (registered read).
  - A read of mtime returns mtime before that cycle's increment.
- Write data:
  - Byte lanes are merged per req_wstrb_i.
  - wstrb=0 is a legal no-op write with a normal response.
  - Registers update on the acceptance edge.
- mtime increment:
  - The prescaler counts 0..TICK_DIV-1. On terminal count it wraps to 0 and tick=1.
  - On tick, mtime <= mtime+1. The full 64-bit counter wraps 2^64-1 -> 0.
  - Carry from low to high word is atomic within the same edge.
- Simultaneous write and tick:
  - A write to either mtime word in a tick cycle wins.
  - Written bytes take the write data; unwritten bytes of that word keep the old value (no +1).
  - The other word is also not incremented that cycle.
  - The prescaler is not reset by mtime writes.
- mtip_o:
  - Registered: mtip_o(t+1) = (mtime(t) >= mtimecmp(t)), unsigned 64-bit compare of post-edge register values.
  - One cycle latency from any mtime or mtimecmp change.
  - It is a level, not a latch: it clears when software raises mtimecmp above mtime.
- msip_o: directly reflects msip bit 0 (registered; visible the cycle after the write edge).
- mtime_o: the mtime register value.
- Reset mid-operation: an accepted request in flight produces no response after reset. Register writes in the reset cycle are discarded.
- No internal state machine beyond the prescaler and the response pipeline stage. Target 150-250 lines.

Test Plan:
- Reset, then read 0x0200_4004 -> resp_valid 1 cycle later, rdata=0xFFFF_FFFF, err=0; mtip_o=0 and msip_o=0 for 100 cycles; mtime_o increments by 1 each cycle (TICK_DIV=1).
- Write 0x0200_4000=0x20, 0x0200_4004=0 after reset -> mtip_o rises exactly 1 cycle after mtime_o reaches 0x20; write 0x0200_4000=0xFFFF_FFFF -> mtip_o falls 1 cycle later.
- Write 0x0200_BFF8=0xFFFF_FFFE, 0x0200_BFFC=0 -> after 2 ticks mtime_o=64'h1_0000_0000; a read of 0x0200_BFFC then returns 1.
- Write msip=0xFFFF_FFFF -> msip_o=1 next cycle and a read returns 0x1; write with wstrb=4'b0000 -> unchanged; write 0 -> msip_o=0.
- Read 0x0200_0004, read 0x0200_4002, and write 0x0200_8000 -> err=1 and rdata=0 on each; no register changes; mtime keeps counting.
- TICK_DIV=4: mtime increments every 4th cycle. A write of mtime low=0x100 in a tick cycle -> mtime_o=0x100, not 0x101. A back-to-back write-then-read of that address returns 0x100.

Source files
------------

// File: rtl/cotm32_clint_if.sv
// CLINT bus interface: single-cycle request, registered one-cycle response.
//   req_valid_i  request strobe (always accepted)
//   req_we_i     1 = write, 0 = read
//   req_addr_i   byte address
//   req_wdata_i  write data
//   req_wstrb_i  write byte enables
//   resp_valid_o response strobe, one cycle after the request
//   resp_rdata_o read data (0 on error)
//   resp_err_o   access fault (unmapped or misaligned)
interface cotm32_clint_if;
  logic        req_valid_i;
  logic        req_we_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [3:0]  req_wstrb_i;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wstrb_i,
    input  resp_valid_o, resp_rdata_o, resp_err_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wstrb_i,
    output resp_valid_o, resp_rdata_o, resp_err_o
  );
endinterface

// File: rtl/cotm32_clint.sv
// Core-local interruptor: msip, mtimecmp and the 64-bit mtime counter
// behind the CLINT MMR window, driving the msip/mtip interrupt lines.
//   clk      core clock
//   rst      synchronous active-high reset
//   bus      CLINT bus responder (cotm32_clint_if.slave)
//   msip_o   machine software interrupt pending
//   mtip_o   machine timer interrupt pending (mtime >= mtimecmp, registered)
//   mtime_o  current mtime value
module cotm32_clint #(
  parameter int unsigned TICK_DIV     = 1,
  parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic                 clk,
  input  logic                 rst,
  cotm32_clint_if.slave        bus,
  output logic                 msip_o,
  output logic                 mtip_o,
  output logic [63:0]          mtime_o
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  localparam logic [31:0] ADDR_MSIP     = 32'h0200_0000;
  localparam logic [31:0] ADDR_CMP_LO   = 32'h0200_4000;
  localparam logic [31:0] ADDR_CMP_HI   = 32'h0200_4004;
  localparam logic [31:0] ADDR_MTIME_LO = 32'h0200_BFF8;
  localparam logic [31:0] ADDR_MTIME_HI = 32'h0200_BFFC;

  logic [PW-1:0] presc_q;
  logic [63:0]   mtime_q;
  logic [63:0]   mtimecmp_q;

  logic          sel_msip;
  logic          sel_cmp_lo;
  logic          sel_cmp_hi;
  logic          sel_time_lo;
  logic          sel_time_hi;
  logic          hit;
  logic          wr;
  logic          tick;
  logic [31:0]   rdata_c;
  logic [PW-1:0] presc_nxt;
  logic [63:0]   mtime_nxt;
  logic [63:0]   cmp_nxt;
  logic          msip_nxt;

  // Byte-lane merge of write data into an existing word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

  assign mtime_o = mtime_q;

  // Address decode, read mux and next-state computation.
  always_comb begin
    sel_msip    = (bus.req_addr_i == ADDR_MSIP);
    sel_cmp_lo  = (bus.req_addr_i == ADDR_CMP_LO);
    sel_cmp_hi  = (bus.req_addr_i == ADDR_CMP_HI);
    sel_time_lo = (bus.req_addr_i == ADDR_MTIME_LO);
    sel_time_hi = (bus.req_addr_i == ADDR_MTIME_HI);
    // Full 32-bit compare also rejects misaligned addresses.
    hit = sel_msip | sel_cmp_lo | sel_cmp_hi | sel_time_lo | sel_time_hi;
    wr  = bus.req_valid_i & bus.req_we_i & hit;

    rdata_c = '0;
    if (sel_msip)         rdata_c = {31'd0, msip_o};
    else if (sel_cmp_lo)  rdata_c = mtimecmp_q[31:0];
    else if (sel_cmp_hi)  rdata_c = mtimecmp_q[63:32];
    else if (sel_time_lo) rdata_c = mtime_q[31:0];
    else if (sel_time_hi) rdata_c = mtime_q[63:32];

    tick      = (presc_q == PRESC_LAST);
    presc_nxt = tick ? '0 : presc_q + PW'(1);

    msip_nxt = msip_o;
    if (wr && sel_msip && bus.req_wstrb_i[0]) msip_nxt = bus.req_wdata_i[0];

    cmp_nxt = mtimecmp_q;
    if (wr && sel_cmp_lo)
      cmp_nxt[31:0] = merge_bytes(mtimecmp_q[31:0], bus.req_wdata_i, bus.req_wstrb_i);
    if (wr && sel_cmp_hi)
      cmp_nxt[63:32] = merge_bytes(mtimecmp_q[63:32], bus.req_wdata_i, bus.req_wstrb_i);

    // A software write to either mtime word suppresses that edge's increment.
    mtime_nxt = tick ? mtime_q + 64'd1 : mtime_q;
    if (wr && sel_time_lo)
      mtime_nxt = {mtime_q[63:32],
                   merge_bytes(mtime_q[31:0], bus.req_wdata_i, bus.req_wstrb_i)};
    else if (wr && sel_time_hi)
      mtime_nxt = {merge_bytes(mtime_q[63:32], bus.req_wdata_i, bus.req_wstrb_i),
                   mtime_q[31:0]};
  end

  // Registers, interrupt lines and the response stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q          <= '0;
      mtime_q          <= '0;
      mtimecmp_q       <= MTIMECMP_RST;
      msip_o           <= 1'b0;
      mtip_o           <= 1'b0;
      bus.resp_valid_o <= 1'b0;
      bus.resp_rdata_o <= '0;
      bus.resp_err_o   <= 1'b0;
    end else begin
      presc_q          <= presc_nxt;
      mtime_q          <= mtime_nxt;
      mtimecmp_q       <= cmp_nxt;
      msip_o           <= msip_nxt;
      mtip_o           <= (mtime_q >= mtimecmp_q);
      bus.resp_valid_o <= bus.req_valid_i;
      if (bus.req_valid_i) begin
        bus.resp_rdata_o <= rdata_c;
        bus.resp_err_o   <= ~hit;
      end
    end
  end

endmodule
